// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module : data_memory
// Brief  : RV32I data RAM with byte-enable stores, load extension, LED and
//          UART-TX memory-mapped peripherals.
// Rev    : 1.0
// ============================================================================
module data_memory #(
    parameter int CLKS_PER_BIT = 868,
    parameter int XLEN         = 32,
    parameter int ALEN         = 32,
    parameter int LED_WIDTH    = 8,
    parameter int RAM_WORDS    = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 MemWrite,
    input  logic [3:0]           be,
    input  logic [2:0]           funct3,
    input  logic [ALEN-1:0]      Address,
    input  logic [XLEN-1:0]      WriteData,
    output logic [XLEN-1:0]      ReadData,
    output logic [LED_WIDTH-1:0] leds_out,
    output logic                 uart_tx_wire
);
    localparam int c_IDX_W = $clog2(RAM_WORDS);
    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [ALEN-1:0] c_LED_ADDR  = ALEN'(32'h8000_0000);
    localparam logic [ALEN-1:0] c_TX_ADDR   = ALEN'(32'h8000_0004);
    localparam logic [ALEN-1:0] c_STAT_ADDR = ALEN'(32'h8000_0008);

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

    logic [XLEN-1:0] ram_memory [RAM_WORDS];

    logic [c_IDX_W-1:0]   w_ram_idx;
    logic                 w_ram_we;
    logic [XLEN-1:0]      w_word;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [XLEN-1:0]      w_ram_rd;
    logic                 w_busy;
    logic                 w_tx_accept;
    logic                 w_cnt_done;

    uart_state_t          state_q, state_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [7:0]           data_q, data_d;
    logic                 tx_q, tx_d;
    logic [LED_WIDTH-1:0] leds_q, leds_d;

    // Bit 31 clear selects RAM; upper address bits alias onto the array.
    assign w_ram_idx   = Address[c_IDX_W+1:2];
    assign w_ram_we    = MemWrite && !Address[ALEN-1];
    assign w_word      = ram_memory[w_ram_idx];
    assign w_busy      = (state_q != S_IDLE);
    assign w_tx_accept = MemWrite && be[0] && (Address == c_TX_ADDR) && !w_busy;
    assign w_cnt_done  = (cnt_q == c_CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    ram_memory[w_ram_idx][8*i +: 8] <= WriteData[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        w_byte = w_word[{Address[1:0], 3'b000} +: 8];
        w_half = Address[1] ? w_word[31:16] : w_word[15:0];
        case (funct3)
            c_F3_LB:  w_ram_rd = {{(XLEN-8){w_byte[7]}}, w_byte};
            c_F3_LH:  w_ram_rd = {{(XLEN-16){w_half[15]}}, w_half};
            c_F3_LBU: w_ram_rd = {{(XLEN-8){1'b0}}, w_byte};
            c_F3_LHU: w_ram_rd = {{(XLEN-16){1'b0}}, w_half};
            default:  w_ram_rd = w_word;
        endcase

        if (!Address[ALEN-1]) begin
            ReadData = w_ram_rd;
        end else if (Address == c_LED_ADDR) begin
            ReadData = XLEN'(leds_q);
        end else if (Address == c_STAT_ADDR) begin
            ReadData = XLEN'(w_busy);
        end else begin
            ReadData = '0;
        end
    end

    always_comb begin
        leds_d = leds_q;
        if (MemWrite && be[0] && (Address == c_LED_ADDR)) begin
            leds_d = WriteData[LED_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (w_tx_accept) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    data_d  = WriteData[7:0];
                end
            end
            S_START: begin
                if (w_cnt_done) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            S_DATA: begin
                if (w_cnt_done) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            S_STOP: begin
                if (w_cnt_done) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Line level follows the next state so it changes on the same edge.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = data_d[idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            data_q  <= 8'h00;
            tx_q    <= 1'b1;
            leds_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            leds_q  <= leds_d;
        end
    end

    assign leds_out     = leds_q;
    assign uart_tx_wire = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
// Module : tb_data_memory
// Brief  : Self-checking bench for data_memory (vector table, random RAM
//          traffic against a word-array model, UART frame sequences).
// Rev    : 1.0
// ============================================================================
module tb_data_memory;
    localparam logic [31:0] c_LED  = 32'h8000_0000;
    localparam logic [31:0] c_TX   = 32'h8000_0004;
    localparam logic [31:0] c_STAT = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemWrite = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] Address = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic [31:0] ReadData;
    logic [7:0]  leds_out;
    logic        uart_tx_wire;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          is_store;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] mdl[int];

    always #5 clk = ~clk;

    data_memory #(
        .CLKS_PER_BIT(4),
        .XLEN(32),
        .ALEN(32),
        .LED_WIDTH(8),
        .RAM_WORDS(4096)
    ) dut (
        .clk(clk),
        .rst(rst),
        .MemWrite(MemWrite),
        .be(be),
        .funct3(funct3),
        .Address(Address),
        .WriteData(WriteData),
        .ReadData(ReadData),
        .leds_out(leds_out),
        .uart_tx_wire(uart_tx_wire)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        @(negedge clk);
        MemWrite  = 1'b1;
        Address   = a;
        be        = b;
        WriteData = d;
        @(negedge clk);
        MemWrite  = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] f, output logic [31:0] r);
        MemWrite = 1'b0;
        Address  = a;
        funct3   = f;
        #1;
        r = ReadData;
    endtask

    function automatic vec_t vs(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        vec_t v;
        v = '{1'b1, a, 3'd2, b, d, 32'h0};
        return v;
    endfunction

    function automatic vec_t vl(input logic [31:0] a, input logic [2:0] f, input logic [31:0] e);
        vec_t v;
        v = '{1'b0, a, f, 4'h0, 32'h0, e};
        return v;
    endfunction

    // Reference load formatting from the raw word using plain arithmetic.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f);
        int unsigned b, h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (f)
            3'd0:    return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
            3'd1:    return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
            3'd4:    return 32'(b);
            3'd5:    return 32'(h);
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] r, m;
        r = old;
        for (int i = 0; i < 4; i++) begin
            m = 32'hFF << (8 * i);
            if (b[i]) r = (r & ~m) | (d & m);
        end
        return r;
    endfunction

    function automatic logic frame_bit(input logic [7:0] d, input int n);
        if (n == 0) return 1'b0;
        if (n == 9) return 1'b1;
        return d[n-1];
    endfunction

    initial begin
        logic [31:0] r;

        // Reset behaviour
        #2 rst = 1'b0;
        #1;
        check("rst_leds", {24'h0, leds_out}, 32'h0);
        check("rst_tx", {31'h0, uart_tx_wire}, 32'h1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        do_load(c_STAT, 3'd2, r);
        check("rst_status", r, 32'h0);

        // Directed vector table
        vecs.push_back(vs(32'h0000_0000, 4'hF, 32'h0050_0113));
        vecs.push_back(vl(32'h0000_0000, 3'd2, 32'h0050_0113));
        vecs.push_back(vl(32'h0000_0003, 3'd4, 32'h0000_0000));
        vecs.push_back(vl(32'h0000_0001, 3'd0, 32'h0000_0001));
        vecs.push_back(vl(32'h0000_0002, 3'd1, 32'h0000_0050));
        vecs.push_back(vs(32'h0000_0100, 4'hF, 32'hDEAD_BEEF));
        vecs.push_back(vs(32'h0000_0100, 4'h4, 32'h00AA_0000));
        vecs.push_back(vl(32'h0000_0100, 3'd2, 32'hDEAA_BEEF));
        vecs.push_back(vl(32'h0000_0102, 3'd1, 32'hFFFF_DEAA));
        vecs.push_back(vl(32'h0000_0102, 3'd5, 32'h0000_DEAA));
        vecs.push_back(vl(32'h0000_0100, 3'd0, 32'hFFFF_FFEF));
        vecs.push_back(vl(32'h0000_0103, 3'd4, 32'h0000_00DE));
        vecs.push_back(vl(32'h0000_0101, 3'd0, 32'hFFFF_FFBE));
        vecs.push_back(vl(32'h0000_0103, 3'd1, 32'hFFFF_DEAA));
        vecs.push_back(vl(32'h0000_0101, 3'd2, 32'hDEAA_BEEF));
        vecs.push_back(vl(32'h0000_0100, 3'd3, 32'hDEAA_BEEF));
        vecs.push_back(vs(32'h0000_0100, 4'h0, 32'hFFFF_FFFF));
        vecs.push_back(vl(32'h0000_0100, 3'd2, 32'hDEAA_BEEF));
        vecs.push_back(vs(32'h0000_4100, 4'hF, 32'h1234_5678));
        vecs.push_back(vl(32'h0000_0100, 3'd2, 32'h1234_5678));
        vecs.push_back(vl(32'h8000_0010, 3'd2, 32'h0000_0000));
        vecs.push_back(vs(32'h8000_0010, 4'hF, 32'hFFFF_FFFF));
        vecs.push_back(vl(c_LED,         3'd2, 32'h0000_0000));
        vecs.push_back(vs(c_LED,         4'h1, 32'h0000_005A));
        vecs.push_back(vl(c_LED,         3'd2, 32'h0000_005A));
        vecs.push_back(vl(c_TX,          3'd2, 32'h0000_0000));
        vecs.push_back(vs(c_LED,         4'hE, 32'h0000_00FF));
        vecs.push_back(vl(c_LED,         3'd2, 32'h0000_005A));

        foreach (vecs[i]) begin
            if (vecs[i].is_store) begin
                do_store(vecs[i].addr, vecs[i].be, vecs[i].wdata);
            end else begin
                do_load(vecs[i].addr, vecs[i].f3, r);
                check($sformatf("vec%0d", i), r, vecs[i].exp);
            end
        end
        check("leds_pin", {24'h0, leds_out}, 32'h0000_005A);

        // Same-cycle read sees old data, next cycle sees new
        @(negedge clk);
        Address   = 32'h0000_0100;
        funct3    = 3'd2;
        be        = 4'hF;
        WriteData = 32'hCAFE_F00D;
        MemWrite  = 1'b1;
        #1;
        check("same_cycle_old", ReadData, 32'h1234_5678);
        @(negedge clk);
        MemWrite = 1'b0;
        #1;
        check("next_cycle_new", ReadData, 32'hCAFE_F00D);

        // Randomised RAM traffic against the word-array model
        for (int w = 128; w < 192; w++) begin
            logic [31:0] d;
            d = $urandom;
            do_store(32'(w) << 2, 4'hF, d);
            mdl[w] = d;
        end
        for (int n = 0; n < 300; n++) begin
            int          idx;
            logic [31:0] a, d;
            logic [3:0]  bb;
            logic [2:0]  f;
            idx = $urandom_range(128, 191);
            a   = ($urandom & 32'h7FFF_C000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                bb = 4'($urandom_range(0, 15));
                d  = $urandom;
                do_store(a, bb, d);
                mdl[idx] = ref_merge(mdl[idx], d, bb);
            end else begin
                f = 3'($urandom_range(0, 7));
                do_load(a, f, r);
                check("rand_load", r, ref_load(mdl[idx], a, f));
            end
        end

        // UART frame of 0x41 with a dropped write while busy
        @(negedge clk);
        #1;
        check("tx_idle_before", {31'h0, uart_tx_wire}, 32'h1);
        do_store(c_TX, 4'h1, 32'h0000_0041);
        Address = c_STAT;
        funct3  = 3'd2;
        for (int k = 0; k < 40; k++) begin
            #1;
            check($sformatf("tx_bit%0d", k), {31'h0, uart_tx_wire}, {31'h0, frame_bit(8'h41, k / 4)});
            if (k != 11) check("status_busy", ReadData, 32'h1);
            if (k == 10) begin
                MemWrite  = 1'b1;
                Address   = c_TX;
                be        = 4'h1;
                WriteData = 32'h0000_0042;
            end else begin
                MemWrite = 1'b0;
                Address  = c_STAT;
            end
            @(negedge clk);
        end
        #1;
        check("tx_after_frame", {31'h0, uart_tx_wire}, 32'h1);
        check("status_idle", ReadData, 32'h0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #1;
            check("tx_no_second_frame", {31'h0, uart_tx_wire}, 32'h1);
        end

        // Reset asserted mid-frame aborts it asynchronously
        do_store(c_TX, 4'h1, 32'h0000_00C3);
        repeat (6) @(negedge clk);
        #1;
        check("tx_mid_frame", {31'h0, uart_tx_wire}, {31'h0, frame_bit(8'hC3, 1)});
        #1 rst = 1'b0;
        #1;
        check("async_rst_tx", {31'h0, uart_tx_wire}, 32'h1);
        check("async_rst_leds", {24'h0, leds_out}, 32'h0);
        do_load(c_STAT, 3'd2, r);
        check("async_rst_status", r, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("tx_idle_after_rst", {31'h0, uart_tx_wire}, 32'h1);
        do_load(32'h0000_0100, 3'd2, r);
        check("ram_kept_over_rst", r, 32'hCAFE_F00D);
        do_store(c_TX, 4'h1, 32'h0000_0001);
        #1;
        check("tx_start_after_rst", {31'h0, uart_tx_wire}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_memory.md
Name: data_memory

Overview:
- Data-side memory for the 5-stage RV32I pipelined CPU: word-organised RAM with byte-enable stores, plus memory-mapped LED and UART-transmit peripherals.
- Load sign/zero extension is done inside this block from funct3, so the CPU's MEM stage consumes ReadData directly.
- The RAM array (ram_memory) is preloadable by the simulator with the same hex image as instruction memory.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud).
- XLEN, 32, data width.
- ALEN, 32, address width.
- LED_WIDTH, 8, width of the LED output register.
- RAM_WORDS, 4096, RAM depth in 32-bit words (16 KiB).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- MemWrite  in  1  store strobe.
- be  in  4  byte-lane enables for stores; bit i selects WriteData[8i+7:8i].
- funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Address  in  ALEN  byte address.
- WriteData  in  XLEN  store data, already lane-aligned by the CPU.
- ReadData  out  XLEN  load result, extended per funct3.
- leds_out  out  LED_WIDTH  LED register.
- uart_tx_wire  out  1  UART serial output, 8N1, idle high.

Behaviour:
- Memory map:
  - RAM at 0x0000_0000–0x0000_3FFF. Word index is Address[13:2]; higher bits below 0x8000_0000 are ignored, so addresses alias and wrap.
  - LED register at 0x8000_0000.
  - UART TX data at 0x8000_0004.
  - UART status at 0x8000_0008: bit0 = busy.
- Reads are combinational; ReadData follows Address and funct3 in the same cycle.
- Read formatting from the selected word w:
  - LB/LBU: byte Address[1:0], sign- or zero-extended.
  - LH/LHU: half Address[1] (Address[0] ignored), sign- or zero-extended.
  - LW: w; Address[1:0] ignored.
  - Undefined funct3 returns w.
- MMIO reads:
  - LED: zero-extended leds_out.
  - Status: {31'b0, busy}.
  - TX data: 0.
- Writes are synchronous on the rising clk edge when MemWrite=1.
  - RAM: each lane with be[i]=1 is updated; other lanes are unchanged.
  - be=0000 writes nothing.
- Write-then-read: a load in the cycle after a store returns the new data. A same-cycle read returns the old data.
- LED write: when MemWrite=1 and be[0]=1, leds_out <= WriteData[LED_WIDTH-1:0].
- UART write: when MemWrite=1, be[0]=1 and not busy, latch WriteData[7:0] and start a frame. A write while busy is dropped.
- UART FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each; a 3-bit index counts 0→7.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - The frame begins in the cycle after the accepting edge.
  - busy=1 from the accepting edge until the STOP period completes.
  - Baud counter range is 0..CLKS_PER_BIT-1.
- Writes to unmapped MMIO addresses are ignored; reads of them return 0.
- Reset (rst low, asynchronous):
  - leds_out=0, uart_tx_wire=1, FSM IDLE, busy=0, counters 0.
  - RAM contents are not cleared.
  - Reset asserted mid-frame aborts the frame immediately and the line goes high.
- Simultaneous store and load: a single address port, so a cycle is either a load or a store. ReadData is still driven combinationally during stores.

Test Plan:
- Preload word0=0x00500113. LW @0x0 returns 0x00500113. LBU @0x3 returns 0x00000000. LB @0x1 returns 0x00000001.
- Store 0xDEADBEEF be=1111 @0x100, then SB 0x000000AA at lane 2 (WriteData=0x00AA0000, be=0100). Then:
  - LW returns 0xDEAABEEF.
  - LH @0x102 returns 0xFFFFDEAA.
  - LHU @0x102 returns 0x0000DEAA.
  - LB @0x100 returns 0xFFFFFFEF.
- Store 0x5A to 0x8000_0000 → leds_out=0x5A next cycle. Reset low mid-run → leds_out=0 asynchronously.
- With CLKS_PER_BIT=4, write 0x41 to 0x8000_0004. uart_tx_wire shows start 0, bits 1,0,0,0,0,0,1,0, stop 1, each for 4 cycles (40 cycles total). Status reads 1 during the frame and 0 after.
- During the busy frame, write 0x42 → dropped; only 0x41 is transmitted.
- Store to 0x4100 and read 0x0100 → same word (aliasing). Read 0x8000_0010 → 0.
